// File: rtl/ram_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// byte-lane helpers used by both the controller and the RAM bank.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Byte enables for a transfer of size_bytes(size) starting at byte offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [15:0] ones;
    ones = (16'd1 << size_bytes(size)) - 16'd1;
    return 8'(ones << offset);
  endfunction

endpackage

// File: rtl/ram_lsu_bank.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port; contents are deliberately not reset.
module ram_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  localparam int BYTES = DATA_W / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BYTES-1:0]  i_be,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_lsu.sv
// Load/store unit: serialised request FSM with wait states, fault detection,
// byte-lane store shifting and sign/zero extension of loads.
module ram_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam int IDXW  = ADDR_W - OFF;
  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  lsu_state_t        r_state;
  logic [2:0]        r_wcnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [OFF-1:0]    r_off;
  logic [AW-1:0]     r_widx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_fault;
  logic              r_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_fault;

  logic [IDXW-1:0]   w_idx;
  logic              w_size_flt;
  logic              w_align_flt;
  logic              w_range_flt;
  logic              w_fault;
  logic [7:0]        w_lanes8;
  logic [BYTES-1:0]  w_be;
  logic [DATA_W-1:0] w_wdata_sh;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_rd_sh;
  logic [7:0]        w_nbits;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign;
  logic [DATA_W-1:0] w_ext;

  // Request checks, evaluated on the live request while IDLE.
  assign w_idx       = req_addr[ADDR_W-1:OFF];
  assign w_size_flt  = (32'd8 << req_size) > 32'(DATA_W);
  assign w_range_flt = {1'b0, w_idx} >= (IDXW+1)'(DEPTH);

  always_comb begin
    w_align_flt = 1'b0;
    case (req_size)
      SZ_B:    w_align_flt = 1'b0;
      SZ_H:    w_align_flt = req_addr[0];
      SZ_W:    w_align_flt = |req_addr[1:0];
      default: w_align_flt = |req_addr[2:0];
    endcase
  end

  assign w_fault = w_size_flt | w_align_flt | w_range_flt;

  // Store path: shift data into its lanes and enable only those bytes.
  assign w_lanes8   = lane_mask(r_size, 3'(r_off));
  assign w_be       = w_lanes8[BYTES-1:0];
  assign w_wdata_sh = r_wdata << {r_off, 3'b000};
  assign w_we       = (r_state == ST_ACCESS) && r_write && !reset;
  assign w_re       = (r_state == ST_ACCESS) && !r_write;

  ram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk     (clock),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_re    (w_re),
    .i_addr  (r_widx),
    .i_wdata (w_wdata_sh),
    .o_rdata (w_ram_rdata)
  );

  // Load path: a full-width access leaves the mask all ones, so no extension.
  assign w_rd_sh = w_ram_rdata >> {r_off, 3'b000};
  assign w_nbits = 8'd8 << r_size;
  assign w_mask  = ~({DATA_W{1'b1}} << w_nbits);
  assign w_sign  = |(w_rd_sh & w_mask & ~(w_mask >> 1));
  assign w_ext   = (r_signed && w_sign) ? (w_rd_sh | ~w_mask) : (w_rd_sh & w_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_ready) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[OFF-1:0];
            r_widx   <= w_idx[AW-1:0];
            r_wdata  <= req_wdata;
            r_fault  <= w_fault;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_wcnt   <= '0;
            if (w_fault)               r_state <= ST_RESP;
            else if (WAIT_STATES > 0)  r_state <= ST_WAIT;
            else                       r_state <= ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (r_wcnt == WS_LAST) r_state <= ST_ACCESS;
          else                   r_wcnt  <= r_wcnt + 3'd1;
        end
        ST_ACCESS: r_state <= ST_RESP;
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_fault <= r_fault;
          r_rsp_rdata <= (r_fault || r_write) ? '0 : w_ext;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

endmodule
